ram_arbiter: RTL and testbench

//  Two-master round-robin arbiter and sequencer for the 32x32 single-port RAM.

---
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter/sequencer for a single-port RAM, one access at a time.
// Define RAM_ARB_FIXED_PRI_EN for fixed m0 priority (default: round-robin).
module ram_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_grant,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_grant,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RDATA
  } state_t;

  state_t                r_state;
  logic                  r_win;
  logic                  r_m0_grant;
  logic                  r_m1_grant;
  logic                  r_m0_rvalid;
  logic                  r_m1_rvalid;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;
  logic                  r_cen;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;

  logic                  w_any;
  logic                  w_pick;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_any = m0_req | m1_req;

  // w_pick: 0 selects m0, 1 selects m1
`ifdef RAM_ARB_FIXED_PRI_EN
  assign w_pick = ~m0_req;
`else
  logic r_last;

  assign w_pick = (m0_req & m1_req) ? ~r_last : m1_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_last <= 1'b1;
    else if (r_state == S_ACCESS)
      r_last <= r_win;
  end
`endif

  assign w_wr    = w_pick ? m1_wr    : m0_wr;
  assign w_addr  = w_pick ? m1_addr  : m0_addr;
  assign w_wdata = w_pick ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_win       <= 1'b0;
      r_m0_grant  <= 1'b0;
      r_m1_grant  <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_cen       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      r_m0_grant  <= 1'b0;
      r_m1_grant  <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_cen       <= 1'b0;
      r_wen       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win      <= w_pick;
            r_cen      <= 1'b1;
            r_wen      <= w_wr;
            r_addr     <= w_addr;
            r_din      <= w_wdata;
            r_m0_grant <= ~w_pick;
            r_m1_grant <= w_pick;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_state <= r_wen ? S_IDLE : S_RDATA;
        end
        S_RDATA: begin
          if (r_win) begin
            r_m1_rdata  <= ram_dout;
            r_m1_rvalid <= 1'b1;
          end else begin
            r_m0_rdata  <= ram_dout;
            r_m0_rvalid <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_grant  = r_m0_grant;
  assign m1_grant  = r_m1_grant;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign ram_cen   = r_cen;
  assign ram_wen   = r_wen;
  assign ram_addr  = r_addr;
  assign ram_din   = r_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 32x32 RAM.
module tb_ram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m0_wr, m0_grant, m0_rvalid;
  logic [4:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_grant, m1_rvalid;
  logic [4:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        ram_cen, ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  int n_chk;
  int n_fail;

  logic [31:0] mem [32];

  ram_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_grant(m0_grant),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_grant(m1_grant),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cen) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      else ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {27'd0, m0_grant, m0_rvalid, m1_grant,
        m1_rvalid, ram_cen}, 32'd0);
    chk({tag, "_wen"}, {31'd0, ram_wen}, 32'd0);
    chk({tag, "_addr"}, {27'd0, ram_addr}, 32'd0);
    chk({tag, "_din"}, ram_din, 32'd0);
    chk({tag, "_m0rd"}, m0_rdata, 32'd0);
    chk({tag, "_m1rd"}, m1_rdata, 32'd0);
  endtask

  int g [4];
  int gi;
  int exp_g [4];
  logic seen;

  initial begin
    n_chk = 0;
    n_fail = 0;
    foreach (mem[i]) mem[i] = 32'd0;
    ram_dout = 32'd0;
    reset_n = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    tick(); tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // m0 write 2 <- 7
    m0_req = 1; m0_wr = 1; m0_addr = 5'h02; m0_wdata = 32'h7;
    tick();
    chk("wr_cen", {31'd0, ram_cen}, 32'd1);
    chk("wr_wen", {31'd0, ram_wen}, 32'd1);
    chk("wr_addr", {27'd0, ram_addr}, 32'd2);
    chk("wr_din", ram_din, 32'd7);
    chk("wr_g0", {31'd0, m0_grant}, 32'd1);
    chk("wr_g1", {31'd0, m1_grant}, 32'd0);
    m0_req = 0;
    m1_req = 1; m1_wr = 0; m1_addr = 5'h02;
    tick();
    chk("wr_c2_cen", {31'd0, ram_cen}, 32'd0);
    chk("wr_c2_hold", {27'd0, ram_addr}, 32'd2);
    chk("wr_c2_g0", {31'd0, m0_grant}, 32'd0);
    // m1 read accepted from cycle 2 => FSM was IDLE in cycle 2
    tick();
    chk("rd_cen", {31'd0, ram_cen}, 32'd1);
    chk("rd_wen", {31'd0, ram_wen}, 32'd0);
    chk("rd_g1", {31'd0, m1_grant}, 32'd1);
    m1_req = 0;
    tick();
    chk("rd_c2_rv", {31'd0, m1_rvalid}, 32'd0);
    tick();
    chk("rd_rv1", {31'd0, m1_rvalid}, 32'd1);
    chk("rd_rd1", m1_rdata, 32'd7);
    chk("rd_rv0", {31'd0, m0_rvalid}, 32'd0);
    chk("rd_rd0", m0_rdata, 32'd0);
    tick();
    chk("rd_rv1_pulse", {31'd0, m1_rvalid}, 32'd0);

    // both hold req from reset
    reset_n = 1'b0;
    m0_req = 1; m0_wr = 1; m0_addr = 5'h03; m0_wdata = 32'hA;
    m1_req = 1; m1_wr = 1; m1_addr = 5'h04; m1_wdata = 32'hB;
    tick();
    reset_n = 1'b1;
`ifdef RAM_ARB_FIXED_PRI_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    g = '{9, 9, 9, 9};
    gi = 0;
    for (int c = 0; c < 20 && gi < 4; c++) begin
      tick();
      if (m0_grant) begin g[gi] = 0; gi++; end
      else if (m1_grant) begin g[gi] = 1; gi++; end
    end
    chk("rr_cnt", gi, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_g%0d", i), g[i], exp_g[i]);
    m0_req = 0; m1_req = 0;
    tick(); tick(); tick();

    // full-range address
    m0_req = 1; m0_wr = 1; m0_addr = 5'h1F; m0_wdata = 32'hFFFF_FFFF;
    tick();
    chk("max_wr_addr", {27'd0, ram_addr}, 32'd31);
    chk("max_wr_din", ram_din, 32'hFFFF_FFFF);
    m0_req = 0;
    m1_req = 1; m1_wr = 0; m1_addr = 5'h1F;
    tick(); tick();
    chk("max_rd_addr", {27'd0, ram_addr}, 32'd31);
    chk("max_rd_g1", {31'd0, m1_grant}, 32'd1);
    m1_req = 0;
    tick(); tick();
    chk("max_rd_rv", {31'd0, m1_rvalid}, 32'd1);
    chk("max_rd_data", m1_rdata, 32'hFFFF_FFFF);
    tick();

    // m1 arrives during m0 read access
    m0_req = 1; m0_wr = 0; m0_addr = 5'h02;
    tick();
    chk("ov_g0", {31'd0, m0_grant}, 32'd1);
    m0_req = 0; m0_addr = 5'h09;
    m1_req = 1; m1_wr = 1; m1_addr = 5'h05; m1_wdata = 32'h55;
    tick();
    chk("ov_c2_g1", {31'd0, m1_grant}, 32'd0);
    chk("ov_c2_addr", {27'd0, ram_addr}, 32'd2);
    tick();
    chk("ov_rv0", {31'd0, m0_rvalid}, 32'd1);
    chk("ov_rd0", m0_rdata, 32'd7);
    chk("ov_c3_g1", {31'd0, m1_grant}, 32'd0);
    tick();
    chk("ov_g1", {31'd0, m1_grant}, 32'd1);
    chk("ov_addr1", {27'd0, ram_addr}, 32'd5);
    chk("ov_din1", ram_din, 32'h55);
    m1_req = 0;
    tick(); tick();

    // reset during RDATA of an m0 read
    m0_req = 1; m0_wr = 0; m0_addr = 5'h05;
    tick();
    chk("rst_g0", {31'd0, m0_grant}, 32'd1);
    m0_req = 0;
    tick();
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_rdata");
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (m0_rvalid) seen = 1'b1;
    end
    chk("rst_no_rv0", {31'd0, seen}, 32'd0);
    chk("rst_m0rd", m0_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
